// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access. Data wins by default; a saturating streak counter forces a
// fetch grant after MAX_D_STREAK back-to-back data grants while fetch waits.
// A flush during a fetch lets the memory transaction finish but hides the
// response from the pipeline.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              pipe_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [STREAK_W-1:0] streak;
    logic                discard;
    logic                d_wins;
    logic                if_ack;
    logic                d_ack;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                if_ready_q;
    logic                d_ready_q;

    // Arbitration decision and ack qualification for the current cycle
    always_comb begin
        d_wins = d_req_i && (!if_req_i || (streak < STREAK_MAX));
        if_ack = (state == GNT_IF) && mem_ack_i;
        d_ack  = (state == GNT_D) && mem_ack_i;
    end

    // Next-state logic: arbitrate in IDLE, wait for ack, then one response cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_wins) begin
                    state_next = GNT_D;
                end else if (if_req_i) begin
                    state_next = GNT_IF;
                end
            end
            GNT_IF, GNT_D: begin
                if (mem_ack_i) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the winning request and track how long fetch has been passed over
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            streak  <= '0;
        end else if (state == IDLE) begin
            if (d_wins) begin
                addr_q  <= d_addr_i;
                we_q    <= d_we_i;
                wdata_q <= d_wdata_i;
                if (!if_req_i) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end else if (if_req_i) begin
                addr_q  <= if_addr_i;
                we_q    <= 1'b0;
                wdata_q <= '0;
                streak  <= '0;
            end
        end
    end

    // Remember a flush against the outstanding fetch until its response slot ends
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            discard <= 1'b0;
        end else if ((state == GNT_IF) && if_flush_i) begin
            discard <= 1'b1;
        end else if (state == RESP) begin
            discard <= 1'b0;
        end
    end

    // Response capture and one-cycle ready pulses for the granted port
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if (if_ack && !(discard || if_flush_i)) begin
                if_ready_q <= 1'b1;
                if_rdata_q <= mem_rdata_i;
            end
            if (d_ack) begin
                d_ready_q <= 1'b1;
                if (!we_q) begin
                    d_rdata_q <= mem_rdata_i;
                end
            end
        end
    end

    assign mem_req_o    = (state == GNT_IF) || (state == GNT_D);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign if_rdata_o   = if_rdata_q;
    assign d_rdata_o    = d_rdata_q;
    assign if_ready_o   = if_ready_q;
    assign d_ready_o    = d_ready_q;
    assign pipe_stall_o = (if_req_i && !if_ready_q) || (d_req_i && !d_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, hand-written
// corner sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MAX_D = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata_o;
    logic        d_ready_o;
    logic        pipe_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests;
    int fails;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          lat;
        logic [31:0] mem_data;
        logic        flush;
        logic        exp_d_gnt;
        logic        exp_if_ready;
        logic        exp_d_ready;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_d_rdata;
    } vec_t;

    vec_t table_v[7];

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_D_STREAK(MAX_D)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .if_req_i(if_req),
        .if_addr_i(if_addr),
        .if_flush_i(if_flush),
        .if_rdata_o(if_rdata_o),
        .if_ready_o(if_ready_o),
        .d_req_i(d_req),
        .d_we_i(d_we),
        .d_addr_i(d_addr),
        .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata_o),
        .d_ready_o(d_ready_o),
        .pipe_stall_o(pipe_stall_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                  input logic dw, input logic [31:0] da, input logic [31:0] dwd);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dwd;
        #1;
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        if_flush  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // One full transaction from IDLE (requests already applied) to the RESP cycle
    task automatic run_txn(input vec_t v);
        logic [31:0] exp_addr;
        exp_addr = v.exp_d_gnt ? v.d_addr : v.if_addr;
        check_output("stall_idle", {63'b0, pipe_stall_o}, {63'b0, v.if_req | v.d_req});
        step();
        check_output("gnt_req", {63'b0, mem_req_o}, 64'd1);
        check_output("gnt_addr", {32'b0, mem_addr_o}, {32'b0, exp_addr});
        check_output("gnt_we", {63'b0, mem_we_o}, {63'b0, v.exp_d_gnt & v.d_we});
        if (v.exp_d_gnt) check_output("gnt_wdata", {32'b0, mem_wdata_o}, {32'b0, v.d_wdata});
        if_flush = v.flush;
        for (int c = 0; c < v.lat; c++) begin
            step();
            if_flush = 1'b0;
            #1;
            check_output("wait_req", {63'b0, mem_req_o}, 64'd1);
            check_output("wait_addr", {32'b0, mem_addr_o}, {32'b0, exp_addr});
            check_output("wait_rdy", {62'b0, if_ready_o, d_ready_o}, 64'd0);
            check_output("wait_stall", {63'b0, pipe_stall_o}, 64'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = v.mem_data;
        step();
        mem_ack   = 1'b0;
        if_flush  = 1'b0;
        mem_rdata = $urandom;
        #1;
        check_output("resp_req", {63'b0, mem_req_o}, 64'd0);
        check_output("resp_if_ready", {63'b0, if_ready_o}, {63'b0, v.exp_if_ready});
        check_output("resp_d_ready", {63'b0, d_ready_o}, {63'b0, v.exp_d_ready});
        check_output("resp_if_rdata", {32'b0, if_rdata_o}, {32'b0, v.exp_if_rdata});
        check_output("resp_d_rdata", {32'b0, d_rdata_o}, {32'b0, v.exp_d_rdata});
        check_output("resp_stall", {63'b0, pipe_stall_o},
                     {63'b0, (v.if_req & ~v.exp_if_ready) | (v.d_req & ~v.exp_d_ready)});
    endtask

    // Leave RESP; the following cycle must be a quiet IDLE
    task automatic idle_step();
        step();
        if_flush = 1'b0;
        #1;
        check_output("idle_req", {63'b0, mem_req_o}, 64'd0);
        check_output("idle_rdy", {62'b0, if_ready_o, d_ready_o}, 64'd0);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] cur_if_rdata;
        logic [31:0] cur_d_rdata;
        int          order_d[10];
        bit          pend_if;
        bit          pend_d;
        logic [31:0] m_if_addr;
        logic [31:0] m_d_addr;
        logic [31:0] m_d_wdata;
        logic        m_d_we;
        int          d_grants_while_fetch_waits;

        tests = 0;
        fails = 0;
        rst = 1'b0;
        if_flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check_output("rst_mem_req", {63'b0, mem_req_o}, 64'd0);
        check_output("rst_mem_we", {63'b0, mem_we_o}, 64'd0);
        check_output("rst_mem_addr", {32'b0, mem_addr_o}, 64'd0);
        check_output("rst_mem_wdata", {32'b0, mem_wdata_o}, 64'd0);
        check_output("rst_ready", {62'b0, if_ready_o, d_ready_o}, 64'd0);
        check_output("rst_if_rdata", {32'b0, if_rdata_o}, 64'd0);
        check_output("rst_d_rdata", {32'b0, d_rdata_o}, 64'd0);
        check_output("rst_stall", {63'b0, pipe_stall_o}, 64'd0);
        do_reset();

        // Directed single-port transactions, including flushes and a store
        table_v[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        3, 32'h00A00093, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00A00093, 32'h0};
        table_v[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00A00093, 32'h0};
        table_v[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h20, 32'h0,        2, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00A00093, 32'hDEADBEEF};
        table_v[3] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0,        2, 32'hBAD0BAD0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00A00093, 32'hDEADBEEF};
        table_v[4] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0,        0, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00A00093, 32'hDEADBEEF};
        table_v[5] = '{1'b1, 32'h30, 1'b0, 1'b0, 32'h0,  32'h0,        1, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000013, 32'hDEADBEEF};
        table_v[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h24, 32'h0,        1, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000013, 32'hCAFEF00D};
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(table_v[i].if_req, table_v[i].if_addr, table_v[i].d_req,
                           table_v[i].d_we, table_v[i].d_addr, table_v[i].d_wdata);
            run_txn(table_v[i]);
            apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            idle_step();
        end

        // Reset while a store is waiting for its ack
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h50, 32'h55AA55AA);
        step();
        check_output("pre_rst_req", {63'b0, mem_req_o}, 64'd1);
        rst = 1'b1;
        d_req = 1'b0;
        #1;
        check_output("midrst_req", {63'b0, mem_req_o}, 64'd0);
        check_output("midrst_we", {63'b0, mem_we_o}, 64'd0);
        check_output("midrst_addr", {32'b0, mem_addr_o}, 64'd0);
        check_output("midrst_if_rdata", {32'b0, if_rdata_o}, 64'd0);
        check_output("midrst_d_rdata", {32'b0, d_rdata_o}, 64'd0);
        step();
        rst = 1'b0;
        #1;
        check_output("postrst_rdy", {62'b0, if_ready_o, d_ready_o}, 64'd0);
        v = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h00100073, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00100073, 32'h0};
        apply_stimulus(v.if_req, v.if_addr, v.d_req, v.d_we, v.d_addr, v.d_wdata);
        run_txn(v);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle_step();

        // Ack with nothing outstanding must be ignored
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF0000;
        step();
        mem_ack = 1'b0;
        #1;
        check_output("spur_req", {63'b0, mem_req_o}, 64'd0);
        check_output("spur_rdy", {62'b0, if_ready_o, d_ready_o}, 64'd0);
        check_output("spur_if_rdata", {32'b0, if_rdata_o}, 64'h00100073);
        step();
        check_output("spur_rdy2", {62'b0, if_ready_o, d_ready_o}, 64'd0);
        check_output("spur_req2", {63'b0, mem_req_o}, 64'd0);

        // Both ports held busy: four data grants, then fetch gets its turn
        order_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        cur_if_rdata = 32'h00100073;
        cur_d_rdata  = 32'h0;
        for (int i = 0; i < 10; i++) begin
            v.if_req = 1'b1;
            v.if_addr = 32'h100 + 32'(i * 4);
            v.d_req = 1'b1;
            v.d_we = 1'b0;
            v.d_addr = 32'h200 + 32'(i * 4);
            v.d_wdata = 32'h0;
            v.lat = 0;
            v.mem_data = 32'hC0000000 + 32'(i);
            v.flush = 1'b0;
            v.exp_d_gnt = (order_d[i] == 1);
            v.exp_if_ready = !v.exp_d_gnt;
            v.exp_d_ready = v.exp_d_gnt;
            if (v.exp_d_gnt) cur_d_rdata = v.mem_data;
            else cur_if_rdata = v.mem_data;
            v.exp_if_rdata = cur_if_rdata;
            v.exp_d_rdata = cur_d_rdata;
            apply_stimulus(v.if_req, v.if_addr, v.d_req, v.d_we, v.d_addr, v.d_wdata);
            run_txn(v);
            idle_step();
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Random traffic checked against a transaction-level model
        do_reset();
        cur_if_rdata = 32'h0;
        cur_d_rdata = 32'h0;
        pend_if = 1'b0;
        pend_d = 1'b0;
        m_if_addr = 32'h0;
        m_d_addr = 32'h0;
        m_d_wdata = 32'h0;
        m_d_we = 1'b0;
        d_grants_while_fetch_waits = 0;
        for (int i = 0; i < 200; i++) begin
            if (!pend_if && ($urandom_range(0, 1) == 1)) begin
                pend_if = 1'b1;
                m_if_addr = $urandom & 32'hFFFFFFFC;
            end
            if (!pend_d && ($urandom_range(0, 1) == 1)) begin
                pend_d = 1'b1;
                m_d_we = 1'($urandom_range(0, 1));
                m_d_addr = $urandom & 32'hFFFFFFFC;
                m_d_wdata = $urandom;
            end
            if (!pend_if && !pend_d) begin
                pend_if = 1'b1;
                m_if_addr = $urandom & 32'hFFFFFFFC;
            end
            apply_stimulus(pend_if, m_if_addr, pend_d, m_d_we, m_d_addr, m_d_wdata);
            v.if_req = pend_if;
            v.if_addr = m_if_addr;
            v.d_req = pend_d;
            v.d_we = m_d_we;
            v.d_addr = m_d_addr;
            v.d_wdata = m_d_wdata;
            v.lat = $urandom_range(0, 3);
            v.mem_data = $urandom;
            v.flush = ($urandom_range(0, 3) == 0);
            v.exp_d_gnt = pend_d && (!pend_if || d_grants_while_fetch_waits < MAX_D);
            if (v.exp_d_gnt && pend_if) d_grants_while_fetch_waits++;
            else d_grants_while_fetch_waits = 0;
            v.exp_d_ready = v.exp_d_gnt;
            v.exp_if_ready = !v.exp_d_gnt && !v.flush;
            if (v.exp_d_gnt && !m_d_we) cur_d_rdata = v.mem_data;
            if (v.exp_if_ready) cur_if_rdata = v.mem_data;
            v.exp_if_rdata = cur_if_rdata;
            v.exp_d_rdata = cur_d_rdata;
            run_txn(v);
            if (v.exp_d_gnt) pend_d = 1'b0;
            else if (v.exp_if_ready) pend_if = 1'b0;
            else m_if_addr = $urandom & 32'hFFFFFFFC;
            apply_stimulus(pend_if, m_if_addr, pend_d, m_d_we, m_d_addr, m_d_wdata);
            if_flush = ($urandom_range(0, 3) == 0);
            idle_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
